led_trail_fader: RTL and testbench

LED_TRAIL_FADER -- requirements
Module: led_trail_fader

---
 rtl/led_pkg.sv | 11 +
 rtl/led_fade_channel.sv | 41 ++++
 rtl/led_trail_fader.sv | 54 +++++
 tb/tb_led_trail_fader.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/led_pkg.sv
// led_pkg: shared definitions for the LED chaser family.
//   LED_LEVEL_BITS : default brightness width used by the family
//   level_t        : brightness level at the default width
//   lmax()         : full-brightness level for a given level width
package led_pkg;
    localparam int LED_LEVEL_BITS = 4;
    typedef logic [LED_LEVEL_BITS-1:0] level_t;
    function automatic int lmax(input int bits);
        return (1 << bits) - 1;
    endfunction
endpackage

// File: rtl/led_fade_channel.sv
// led_fade_channel: one LED's brightness level with load/decay and PWM compare.
//   clk, rst   : clock, async active-high reset
//   enable     : freezes the level when low
//   led        : chaser input, reloads full brightness
//   decay_tick : shared one-level decay strobe
//   pwm_cnt    : shared PWM ramp
//   pwm        : registered PWM drive
//   active     : level is nonzero
module led_fade_channel
    import led_pkg::*;
#(
    parameter int LEVEL_BITS = LED_LEVEL_BITS
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  enable,
    input  logic                  led,
    input  logic                  decay_tick,
    input  logic [LEVEL_BITS-1:0] pwm_cnt,
    output logic                  pwm,
    output logic                  active
);
    localparam logic [LEVEL_BITS-1:0] LMAX = LEVEL_BITS'(lmax(LEVEL_BITS));
    logic [LEVEL_BITS-1:0] level, level_next;
    // a lit LED wins over a simultaneous decay step; decay saturates at zero
    always_comb begin
        level_next = level;
        if (enable)
            level_next = led ? LMAX : (decay_tick && level != '0) ? level - 1'b1 : level;
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            level <= '0;
            pwm   <= 1'b0;
        end else begin
            level <= level_next;
            pwm   <= pwm_cnt < level;
        end
    end
    assign active = level != '0;
endmodule

// File: rtl/led_trail_fader.sv
// led_trail_fader: fading trail behind a light chaser, PWM-dimmed per LED.
//   clk, rst   : clock, async active-high reset
//   enable     : freezes fade state (PWM keeps running) when low
//   led_in     : chaser pattern
//   pwm_out    : registered PWM drive per LED
//   any_active : registered flag, some LED level is nonzero
module led_trail_fader
    import led_pkg::*;
#(
    parameter int WIDTH       = 8,
    parameter int LEVEL_BITS  = LED_LEVEL_BITS,
    parameter int DECAY_TICKS = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    input  logic [WIDTH-1:0] led_in,
    output logic [WIDTH-1:0] pwm_out,
    output logic             any_active
);
    localparam int PW = $clog2(DECAY_TICKS);
    localparam logic [PW-1:0] PRE_LAST = PW'(DECAY_TICKS - 1);
    // the ramp stops one short of LMAX so a full level stays constantly on
    localparam logic [LEVEL_BITS-1:0] PWM_LAST = LEVEL_BITS'(lmax(LEVEL_BITS) - 1);
    logic [PW-1:0]         presc;
    logic [LEVEL_BITS-1:0] pwm_cnt;
    logic [WIDTH-1:0]      active;
    logic                  decay_tick;
    assign decay_tick = enable && presc == PRE_LAST;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            presc      <= '0;
            pwm_cnt    <= '0;
            any_active <= 1'b0;
        end else begin
            if (enable)
                presc <= decay_tick ? '0 : presc + 1'b1;
            pwm_cnt    <= pwm_cnt == PWM_LAST ? '0 : pwm_cnt + 1'b1;
            any_active <= |active;
        end
    end
    for (genvar g = 0; g < WIDTH; g++) begin : g_ch
        led_fade_channel #(.LEVEL_BITS(LEVEL_BITS)) u_ch (
            .clk        (clk),
            .rst        (rst),
            .enable     (enable),
            .led        (led_in[g]),
            .decay_tick (decay_tick),
            .pwm_cnt    (pwm_cnt),
            .pwm        (pwm_out[g]),
            .active     (active[g])
        );
    end
endmodule

// File: tb/tb_led_trail_fader.sv
// tb_led_trail_fader: scoreboard bench for led_trail_fader (WIDTH=8, LMAX=15, DECAY_TICKS=4).
module tb_led_trail_fader;
    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       en = 1'b0;
    logic [7:0] led = 8'h00;
    logic [7:0] pwm_out;
    logic       any_active;
    int checks = 0;
    int failures = 0;
    int m_lvl[8];
    int m_presc;
    int m_pwm;
    logic [8:0] q[$];
    logic [8:0] exp_v;

    led_trail_fader #(.WIDTH(8), .LEVEL_BITS(4), .DECAY_TICKS(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .enable     (en),
        .led_in     (led),
        .pwm_out    (pwm_out),
        .any_active (any_active)
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        for (int i = 0; i < 8; i++) m_lvl[i] = 0;
        m_presc = 0;
        m_pwm = 0;
        q.delete();
    endtask

    // advance one clock; the model predicts the outputs from pre-edge state and inputs
    task automatic tick();
        logic t;
        logic [7:0] np;
        logic na;
        @(posedge clk);
        t = en && m_presc == 3;
        na = 1'b0;
        for (int i = 0; i < 8; i++) begin
            np[i] = m_pwm < m_lvl[i];
            na = na | (m_lvl[i] != 0);
        end
        for (int i = 0; i < 8; i++)
            if (en) m_lvl[i] = led[i] ? 15 : (t && m_lvl[i] != 0) ? m_lvl[i] - 1 : m_lvl[i];
        if (en) m_presc = t ? 0 : m_presc + 1;
        m_pwm = m_pwm == 14 ? 0 : m_pwm + 1;
        q.push_back({np, na});
        #1;
    endtask

    task automatic test_reset();
        #3 rst = 1'b1;
        #1;
        checks++;
        if (pwm_out !== 8'h00 || any_active !== 1'b0) begin
            failures++;
            $display("FAIL reset_initial got pwm=%h any=%b exp pwm=00 any=0", pwm_out, any_active);
        end
        @(posedge clk);
        #1 rst = 1'b0;
        model_reset();
    endtask

    task automatic test_full_on();
        en = 1'b1;
        led = 8'h01;
        for (int c = 0; c < 20; c++) begin
            tick();
            exp_v = q.pop_front();
            checks++;
            if ({pwm_out, any_active} !== exp_v) begin
                failures++;
                $display("FAIL full_on_model cyc=%0d got=%h exp=%h", c, {pwm_out, any_active}, exp_v);
            end
            if (c >= 1) begin
                checks++;
                if (pwm_out !== 8'h01 || any_active !== 1'b1) begin
                    failures++;
                    $display("FAIL full_on_const cyc=%0d got pwm=%h any=%b exp pwm=01 any=1", c, pwm_out, any_active);
                end
            end
        end
    endtask

    task automatic test_async_reset();
        #2 rst = 1'b1;
        #1;
        checks++;
        if (pwm_out !== 8'h00 || any_active !== 1'b0) begin
            failures++;
            $display("FAIL async_reset got pwm=%h any=%b exp pwm=00 any=0", pwm_out, any_active);
        end
        @(posedge clk);
        #1 rst = 1'b0;
        model_reset();
        led = 8'h01;
        tick();
        tick();
        void'(q.pop_front());
        void'(q.pop_front());
    endtask

    task automatic test_fade();
        led = 8'h00;
        for (int c = 0; c < 66; c++) begin
            tick();
            exp_v = q.pop_front();
            checks++;
            if ({pwm_out, any_active} !== exp_v) begin
                failures++;
                $display("FAIL fade_model cyc=%0d got=%h exp=%h", c, {pwm_out, any_active}, exp_v);
            end
        end
        checks++;
        if (pwm_out !== 8'h00 || any_active !== 1'b0) begin
            failures++;
            $display("FAIL fade_end got pwm=%h any=%b exp pwm=00 any=0", pwm_out, any_active);
        end
    endtask

    task automatic test_reload();
        int guard;
        int highs;
        led = 8'h01;
        tick();
        void'(q.pop_front());
        led = 8'h00;
        guard = 0;
        while (!(m_lvl[0] == 3 && m_presc == 3) && guard < 200) begin
            tick();
            exp_v = q.pop_front();
            checks++;
            if ({pwm_out, any_active} !== exp_v) begin
                failures++;
                $display("FAIL reload_model cyc=%0d got=%h exp=%h", guard, {pwm_out, any_active}, exp_v);
            end
            guard++;
        end
        checks++;
        if (guard >= 200) begin
            failures++;
            $display("FAIL reload_reach got=timeout exp=level3_at_tick");
        end
        led = 8'h01;
        tick();
        void'(q.pop_front());
        tick();
        void'(q.pop_front());
        highs = 0;
        for (int c = 0; c < 15; c++) begin
            tick();
            exp_v = q.pop_front();
            highs += int'(pwm_out[0]);
            checks++;
            if ({pwm_out, any_active} !== exp_v) begin
                failures++;
                $display("FAIL reload_after cyc=%0d got=%h exp=%h", c, {pwm_out, any_active}, exp_v);
            end
        end
        checks++;
        if (highs != 15) begin
            failures++;
            $display("FAIL reload_duty got=%0d exp=15", highs);
        end
    endtask

    task automatic test_freeze();
        int guard;
        int highs;
        led = 8'h00;
        guard = 0;
        while (m_lvl[0] != 7 && guard < 200) begin
            tick();
            exp_v = q.pop_front();
            checks++;
            if ({pwm_out, any_active} !== exp_v) begin
                failures++;
                $display("FAIL freeze_pre cyc=%0d got=%h exp=%h", guard, {pwm_out, any_active}, exp_v);
            end
            guard++;
        end
        checks++;
        if (guard >= 200) begin
            failures++;
            $display("FAIL freeze_reach got=timeout exp=level7");
        end
        en = 1'b0;
        highs = 0;
        for (int c = 0; c < 40; c++) begin
            led = c[0] ? 8'hFF : 8'h00;
            tick();
            exp_v = q.pop_front();
            if (c >= 25) highs += int'(pwm_out[0]);
            checks++;
            if ({pwm_out, any_active} !== exp_v) begin
                failures++;
                $display("FAIL freeze_hold cyc=%0d got=%h exp=%h", c, {pwm_out, any_active}, exp_v);
            end
        end
        checks++;
        if (highs != 7) begin
            failures++;
            $display("FAIL freeze_duty got=%0d exp=7", highs);
        end
        en = 1'b1;
        led = 8'h00;
        for (int c = 0; c < 20; c++) begin
            tick();
            exp_v = q.pop_front();
            checks++;
            if ({pwm_out, any_active} !== exp_v) begin
                failures++;
                $display("FAIL freeze_resume cyc=%0d got=%h exp=%h", c, {pwm_out, any_active}, exp_v);
            end
        end
    endtask

    task automatic test_chaser();
        for (int c = 0; c < 144; c++) begin
            led = c < 64 ? 8'h01 << ((c / 4) % 8) : 8'h00;
            tick();
            exp_v = q.pop_front();
            checks++;
            if ({pwm_out, any_active} !== exp_v) begin
                failures++;
                $display("FAIL chaser_model cyc=%0d got=%h exp=%h", c, {pwm_out, any_active}, exp_v);
            end
        end
        checks++;
        if (pwm_out !== 8'h00 || any_active !== 1'b0) begin
            failures++;
            $display("FAIL chaser_end got pwm=%h any=%b exp pwm=00 any=0", pwm_out, any_active);
        end
    endtask

    task automatic test_reset_mid_fade();
        led = 8'hFF;
        tick();
        void'(q.pop_front());
        led = 8'h00;
        for (int c = 0; c < 10; c++) begin
            tick();
            void'(q.pop_front());
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if (pwm_out !== 8'h00 || any_active !== 1'b0) begin
            failures++;
            $display("FAIL midfade_reset got pwm=%h any=%b exp pwm=00 any=0", pwm_out, any_active);
        end
        @(posedge clk);
        #1 rst = 1'b0;
        model_reset();
        for (int c = 0; c < 40; c++) begin
            tick();
            exp_v = q.pop_front();
            checks++;
            if ({pwm_out, any_active} !== exp_v || {pwm_out, any_active} !== 9'h000) begin
                failures++;
                $display("FAIL midfade_after cyc=%0d got=%h exp=%h", c, {pwm_out, any_active}, exp_v);
            end
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_full_on();
        test_async_reset();
        test_fade();
        test_reload();
        test_freeze();
        test_chaser();
        test_reset_mid_fade();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
